// File: rtl/dsc_pkg.sv
// Shared constants, state type and field helpers for the descriptor dispatcher.
package dsc_pkg;

    localparam int PASID_LSB     = 992;
    localparam int PASID_MSB     = 1000;
    localparam int DSC_MAGIC_LSB = 16;
    localparam int DSC_MAGIC_MSB = 31;
    localparam logic [15:0] DSC_MAGIC = 16'h20F8;
    localparam int DSC_VALID_BIT = 0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } dsc_state_e;

    function automatic logic [PASID_MSB-PASID_LSB:0] dsc_pasid(input logic [1023:0] dsc);
        return dsc[PASID_MSB:PASID_LSB];
    endfunction

endpackage

// File: rtl/dsc_dispatcher_if.sv
// Descriptor FIFO, engine and completion channels of the dispatcher.
interface dsc_dispatcher_if #(
    parameter int NUM_ENGINES  = 4,
    parameter int DATA_WIDTH   = 1024,
    parameter int PASID_WIDTH  = 9,
    parameter int ENG_ID_WIDTH = 4
);
    logic                    dsc_ready_i;
    logic [DATA_WIDTH-1:0]   dsc_data_i;
    logic                    dsc_pull_o;
    logic [NUM_ENGINES-1:0]  eng_valid_o;
    logic [NUM_ENGINES-1:0]  eng_ready_i;
    logic [DATA_WIDTH-1:0]   eng_data_o;
    logic [NUM_ENGINES-1:0]  eng_done_i;
    logic [NUM_ENGINES-1:0]  eng_done_ack_o;
    logic                    cmpl_valid_o;
    logic                    cmpl_ready_i;
    logic [ENG_ID_WIDTH-1:0] cmpl_eng_o;
    logic [PASID_WIDTH-1:0]  cmpl_pasid_o;

    modport master (
        input  dsc_ready_i, dsc_data_i, eng_ready_i, eng_done_i, cmpl_ready_i,
        output dsc_pull_o, eng_valid_o, eng_data_o, eng_done_ack_o,
               cmpl_valid_o, cmpl_eng_o, cmpl_pasid_o
    );

    modport slave (
        output dsc_ready_i, dsc_data_i, eng_ready_i, eng_done_i, cmpl_ready_i,
        input  dsc_pull_o, eng_valid_o, eng_data_o, eng_done_ack_o,
               cmpl_valid_o, cmpl_eng_o, cmpl_pasid_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; the search starts after the
// last accepted grant and the pointer only moves when a grant is accepted.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [N-1:0]   req_i,
    input  logic           accept_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_idx_o,
    output logic           valid_o
);
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [N-1:0]   grant_s;
    logic [IDW-1:0] idx_s;
    logic           valid_s;
    logic [N-1:0]   req_sh_s;
    int             cand_s;

    // Rotating priority search: nearest requester after the pointer wins.
    always_comb begin
        grant_s  = '0;
        idx_s    = '0;
        valid_s  = 1'b0;
        req_sh_s = '0;
        cand_s   = 0;
        for (int k = 1; k <= N; k++) begin
            cand_s   = (int'(ptr_q) + k) % N;
            req_sh_s = req_i >> cand_s;
            if (!valid_s && req_sh_s[0]) begin
                valid_s = 1'b1;
                grant_s = N'(1'b1) << cand_s;
                idx_s   = IDW'(cand_s);
            end else begin
                valid_s = valid_s;
            end
        end
        if (accept_i && valid_s) begin
            ptr_d = idx_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer starts at the last engine so engine 0 is served first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= IDW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o     = grant_s;
    assign grant_idx_o = idx_s;
    assign valid_o     = valid_s;
endmodule

// File: rtl/dsc_dispatcher.sv
// Round-robin descriptor dispatcher: pops descriptors, issues them to idle
// enabled engines, and serialises tagged completions onto one channel.
module dsc_dispatcher
    import dsc_pkg::*;
#(
    parameter int NUM_ENGINES  = 4,
    parameter int DATA_WIDTH   = 1024,
    parameter int PASID_WIDTH  = 9,
    parameter int ENG_ID_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    dsc_dispatcher_if.master       bus,
    input  logic [NUM_ENGINES-1:0] eng_enable_i,
    input  logic                   halt_i,
    output logic [NUM_ENGINES-1:0] busy_o,
    output logic                   idle_o,
    output logic [31:0]            dispatched_cnt_o,
    output logic [31:0]            completed_cnt_o
);
    localparam int N   = NUM_ENGINES;
    localparam int IDW = ENG_ID_WIDTH;
    localparam int PW  = PASID_WIDTH;

    dsc_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [N-1:0]          grant_q, grant_d;
    logic [IDW-1:0]        grant_idx_q, grant_idx_d;
    logic [N-1:0]          busy_q, busy_d;
    logic [PW-1:0]         pasid_tab_q [N];
    logic [PW-1:0]         pasid_tab_d [N];
    logic [31:0]           disp_cnt_q, disp_cnt_d;
    logic [31:0]           cmpl_cnt_q, cmpl_cnt_d;
    logic                  cmpl_valid_q, cmpl_valid_d;
    logic [IDW-1:0]        cmpl_eng_q, cmpl_eng_d;
    logic [PW-1:0]         cmpl_pasid_q, cmpl_pasid_d;
    logic [N-1:0]          ack_q, ack_d;

    logic [N-1:0]   eligible_s, arb_grant_s, busy_set_s, busy_clr_s, cand_s;
    logic [IDW-1:0] arb_idx_s;
    logic           arb_valid_s, pull_s, load_s, found_s;
    logic [PW-1:0]  pasid_in_s;

    // Grant eligibility uses registered busy, so a completing engine is only
    // re-granted once its busy bit has actually cleared.
    assign eligible_s = eng_enable_i & ~busy_q;
    assign pasid_in_s = PW'(hold_q[PASID_MSB:PASID_LSB]);

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .clk         (clk),
        .resetn      (resetn),
        .req_i       (eligible_s),
        .accept_i    (pull_s),
        .grant_o     (arb_grant_s),
        .grant_idx_o (arb_idx_s),
        .valid_o     (arb_valid_s)
    );

    // Dispatch FSM: pop and grant in IDLE, hold the offer in ISSUE until taken.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        pasid_tab_d = pasid_tab_q;
        disp_cnt_d  = disp_cnt_q;
        busy_set_s  = '0;
        pull_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dsc_ready_i && !halt_i && arb_valid_s) begin
                    pull_s      = 1'b1;
                    hold_d      = bus.dsc_data_i;
                    grant_d     = arb_grant_s;
                    grant_idx_d = arb_idx_s;
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if ((grant_q & bus.eng_ready_i) != '0) begin
                    busy_set_s = grant_q;
                    grant_d    = '0;
                    disp_cnt_d = disp_cnt_q + 32'd1;
                    state_d    = IDLE;
                    for (int i = 0; i < N; i++) begin
                        if (IDW'(i) == grant_idx_q) begin
                            pasid_tab_d[i] = pasid_in_s;
                        end else begin
                            pasid_tab_d[i] = pasid_tab_q[i];
                        end
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Completion path: lowest-index done engine loads when the record drains.
    always_comb begin
        cand_s       = bus.eng_done_i & busy_q;
        load_s       = !cmpl_valid_q || bus.cmpl_ready_i;
        cmpl_valid_d = cmpl_valid_q;
        cmpl_eng_d   = cmpl_eng_q;
        cmpl_pasid_d = cmpl_pasid_q;
        ack_d        = '0;
        busy_clr_s   = '0;
        found_s      = 1'b0;
        if (cmpl_valid_q && bus.cmpl_ready_i) begin
            cmpl_cnt_d   = cmpl_cnt_q + 32'd1;
            cmpl_valid_d = 1'b0;
        end else begin
            cmpl_cnt_d = cmpl_cnt_q;
        end
        if (load_s) begin
            for (int i = 0; i < N; i++) begin
                if (cand_s[i] && !found_s) begin
                    found_s       = 1'b1;
                    cmpl_valid_d  = 1'b1;
                    cmpl_eng_d    = IDW'(i);
                    cmpl_pasid_d  = pasid_tab_q[i];
                    ack_d[i]      = 1'b1;
                    busy_clr_s[i] = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
        busy_d = (busy_q | busy_set_s) & ~busy_clr_s;
    end

    // State, holding register, busy/PASID tracking and completion record.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            grant_q      <= '0;
            grant_idx_q  <= '0;
            busy_q       <= '0;
            disp_cnt_q   <= 32'd0;
            cmpl_cnt_q   <= 32'd0;
            cmpl_valid_q <= 1'b0;
            cmpl_eng_q   <= '0;
            cmpl_pasid_q <= '0;
            ack_q        <= '0;
            for (int i = 0; i < N; i++) begin
                pasid_tab_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            grant_q      <= grant_d;
            grant_idx_q  <= grant_idx_d;
            busy_q       <= busy_d;
            disp_cnt_q   <= disp_cnt_d;
            cmpl_cnt_q   <= cmpl_cnt_d;
            cmpl_valid_q <= cmpl_valid_d;
            cmpl_eng_q   <= cmpl_eng_d;
            cmpl_pasid_q <= cmpl_pasid_d;
            ack_q        <= ack_d;
            pasid_tab_q  <= pasid_tab_d;
        end
    end

    assign bus.dsc_pull_o     = pull_s;
    assign bus.eng_valid_o    = grant_q;
    assign bus.eng_data_o     = hold_q;
    assign bus.eng_done_ack_o = ack_q;
    assign bus.cmpl_valid_o   = cmpl_valid_q;
    assign bus.cmpl_eng_o     = cmpl_eng_q;
    assign bus.cmpl_pasid_o   = cmpl_pasid_q;
    assign busy_o             = busy_q;
    assign idle_o             = (state_q == IDLE) && (busy_q == '0) && !cmpl_valid_q;
    assign dispatched_cnt_o   = disp_cnt_q;
    assign completed_cnt_o    = cmpl_cnt_q;
endmodule

// File: tb/tb_dsc_dispatcher.sv
// Bench for dsc_dispatcher: table of dispatch scenarios plus hand-written
// completion, back-pressure, halt and reset sequences with a completion scoreboard.
module tb_dsc_dispatcher;
    import dsc_pkg::*;

    localparam int NE = 4;
    localparam int DW = 1024;
    localparam int PW = 9;
    localparam int IW = 4;

    typedef struct {
        logic [3:0]  enable;
        int          n_desc;
        int          exp_n;
        logic [15:0] exp_seq;
        logic [3:0]  exp_busy;
    } disp_vec_t;

    typedef struct {
        logic [IW-1:0] eng;
        logic [PW-1:0] pasid;
    } cmpl_rec_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [NE-1:0] eng_enable_i;
    logic          halt_i;
    logic [NE-1:0] busy_o;
    logic          idle_o;
    logic [31:0]   dispatched_cnt_o;
    logic [31:0]   completed_cnt_o;

    dsc_dispatcher_if #(.NUM_ENGINES(NE), .DATA_WIDTH(DW), .PASID_WIDTH(PW), .ENG_ID_WIDTH(IW)) bus ();

    dsc_dispatcher #(.NUM_ENGINES(NE), .DATA_WIDTH(DW), .PASID_WIDTH(PW), .ENG_ID_WIDTH(IW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .bus              (bus),
        .eng_enable_i     (eng_enable_i),
        .halt_i           (halt_i),
        .busy_o           (busy_o),
        .idle_o           (idle_o),
        .dispatched_cnt_o (dispatched_cnt_o),
        .completed_cnt_o  (completed_cnt_o)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            n_pull = 0;
    logic [DW-1:0] fifo [$];
    logic [DW-1:0] inflight;
    logic          have_inflight;
    cmpl_rec_t     sb [$];
    int            disp_log [$];
    int            disp_cyc [$];
    int            cmpl_cyc [$];
    logic [PW-1:0] pasid_exp [NE];
    logic [NE-1:0] en, eng_rdy, done_lvl;
    logic          halt, cmpl_rdy;
    disp_vec_t     vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_dsc(input logic [PW-1:0] pasid, input int tag);
        logic [DW-1:0] d;
        d = '0;
        d[DSC_MAGIC_MSB:DSC_MAGIC_LSB] = DSC_MAGIC;
        d[DSC_VALID_BIT] = 1'b1;
        d[63:32] = 32'(tag);
        d[PASID_MSB:PASID_LSB] = pasid;
        d[1023:1001] = 23'(tag * 7919);
        return d;
    endfunction

    task automatic push_dsc(input logic [PW-1:0] pasid);
        fifo.push_back(mk_dsc(pasid, fifo.size() + 100));
    endtask

    // Raise done on the masked engines; expected records go in index order.
    task automatic raise_done(input logic [NE-1:0] mask);
        cmpl_rec_t r;
        for (int k = 0; k < NE; k++) begin
            if (mask[k]) begin
                r.eng   = IW'(k);
                r.pasid = pasid_exp[k];
                sb.push_back(r);
                done_lvl[k] = 1'b1;
            end
        end
    endtask

    // One cycle: drive at the falling edge, observe 1 time unit later.
    task automatic step();
        cmpl_rec_t r;
        int        idx;
        @(negedge clk);
        bus.dsc_ready_i  = (fifo.size() != 0);
        bus.dsc_data_i   = (fifo.size() != 0) ? fifo[0] : '0;
        bus.eng_ready_i  = eng_rdy;
        bus.eng_done_i   = done_lvl;
        bus.cmpl_ready_i = cmpl_rdy;
        eng_enable_i     = en;
        halt_i           = halt;
        #1;
        if (bus.dsc_pull_o) begin
            n_pull++;
            if (fifo.size() == 0) begin
                check("pull_on_empty", 64'(1), 64'(0));
            end else begin
                inflight      = fifo.pop_front();
                have_inflight = 1'b1;
            end
        end
        if ((bus.eng_valid_o & bus.eng_ready_i) != '0) begin
            idx = 0;
            for (int k = NE - 1; k >= 0; k--) begin
                if (bus.eng_valid_o[k]) idx = k;
            end
            check("dsp_onehot", 64'($countones(bus.eng_valid_o)), 64'(1));
            check("dsp_data", 64'(have_inflight && (bus.eng_data_o == inflight)), 64'(1));
            pasid_exp[idx] = dsc_pasid(inflight);
            have_inflight  = 1'b0;
            disp_log.push_back(idx);
            disp_cyc.push_back(cyc);
        end
        if (bus.cmpl_valid_o && bus.cmpl_ready_i) begin
            if (sb.size() == 0) begin
                check("cmpl_unexpected", 64'(bus.cmpl_eng_o), 64'hFFFF);
            end else begin
                r = sb.pop_front();
                check("cmpl_eng", 64'(bus.cmpl_eng_o), 64'(r.eng));
                check("cmpl_pasid", 64'(bus.cmpl_pasid_o), 64'(r.pasid));
            end
            cmpl_cyc.push_back(cyc);
        end
        for (int k = 0; k < NE; k++) begin
            if (bus.eng_done_ack_o[k]) done_lvl[k] = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        fifo.delete();
        sb.delete();
        disp_log.delete();
        disp_cyc.delete();
        cmpl_cyc.delete();
        have_inflight = 1'b0;
        inflight = '0;
        en = '0;
        eng_rdy = '1;
        done_lvl = '0;
        halt = 1'b0;
        cmpl_rdy = 1'b1;
        n_pull = 0;
        for (int k = 0; k < NE; k++) pasid_exp[k] = '0;
        repeat (2) step();
        resetn = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int bad;
        vecs[0] = '{enable: 4'hF, n_desc: 5, exp_n: 4, exp_seq: 16'h3210, exp_busy: 4'hF};
        vecs[1] = '{enable: 4'h5, n_desc: 3, exp_n: 2, exp_seq: 16'h0020, exp_busy: 4'h5};
        vecs[2] = '{enable: 4'hA, n_desc: 2, exp_n: 2, exp_seq: 16'h0031, exp_busy: 4'hA};
        vecs[3] = '{enable: 4'h8, n_desc: 2, exp_n: 1, exp_seq: 16'h0003, exp_busy: 4'h8};
        vecs[4] = '{enable: 4'h0, n_desc: 1, exp_n: 0, exp_seq: 16'h0000, exp_busy: 4'h0};

        do_reset();
        check("rst_idle", 64'(idle_o), 64'(1));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_valid", 64'(bus.eng_valid_o), 64'(0));
        check("rst_cmpl_valid", 64'(bus.cmpl_valid_o), 64'(0));
        check("rst_cnts", 64'({dispatched_cnt_o, completed_cnt_o}), 64'(0));

        for (int r = 0; r < 5; r++) begin
            do_reset();
            en = vecs[r].enable;
            for (int j = 0; j < vecs[r].n_desc; j++) push_dsc(PW'(16 + r * 8 + j));
            repeat (20) step();
            check($sformatf("row%0d_ndisp", r), 64'(disp_log.size()), 64'(vecs[r].exp_n));
            for (int j = 0; j < vecs[r].exp_n && j < disp_log.size(); j++) begin
                check($sformatf("row%0d_eng%0d", r, j), 64'(disp_log[j]), 64'(vecs[r].exp_seq[4*j +: 4]));
                check($sformatf("row%0d_cyc%0d", r, j), 64'(disp_cyc[j]), 64'(2 * j + 1));
            end
            check($sformatf("row%0d_busy", r), 64'(busy_o), 64'(vecs[r].exp_busy));
            check($sformatf("row%0d_dcnt", r), 64'(dispatched_cnt_o), 64'(vecs[r].exp_n));
            check($sformatf("row%0d_left", r), 64'(fifo.size()), 64'(vecs[r].n_desc - vecs[r].exp_n));
        end

        // Masked engines: third descriptor waits for engine 0 to complete.
        do_reset();
        en = 4'b0101;
        for (int j = 0; j < 3; j++) push_dsc(PW'(40 + j));
        repeat (20) step();
        check("mask_wait", 64'(disp_log.size()), 64'(2));
        raise_done(4'b0001);
        repeat (8) step();
        check("mask_ndisp", 64'(disp_log.size()), 64'(3));
        check("mask_third", 64'((disp_log.size() > 2) ? disp_log[2] : 99), 64'(0));
        check("mask_ccnt", 64'(completed_cnt_o), 64'(1));
        check("mask_busy", 64'(busy_o), 64'(4'b0101));
        check("mask_sb", 64'(sb.size()), 64'(0));

        // Simultaneous completions on engines 1 and 3.
        do_reset();
        en = 4'hF;
        push_dsc(9'h033); push_dsc(9'h005); push_dsc(9'h077); push_dsc(9'h01A);
        repeat (12) step();
        check("pair_pasid1", 64'(pasid_exp[1]), 64'(9'h005));
        check("pair_pasid3", 64'(pasid_exp[3]), 64'(9'h01A));
        raise_done(4'b1010);
        repeat (6) step();
        check("pair_n", 64'(cmpl_cyc.size()), 64'(2));
        check("pair_b2b", 64'((cmpl_cyc.size() == 2) ? cmpl_cyc[1] - cmpl_cyc[0] : 0), 64'(1));
        check("pair_ccnt", 64'(completed_cnt_o), 64'(2));
        check("pair_busy", 64'(busy_o), 64'(4'b0101));
        check("pair_sb", 64'(sb.size()), 64'(0));

        // Back-pressure: one record held stable while three engines are done.
        do_reset();
        en = 4'hF;
        for (int j = 0; j < 4; j++) push_dsc(PW'(200 + j * 11));
        repeat (12) step();
        cmpl_rdy = 1'b0;
        raise_done(4'b0111);
        step();
        step();
        check("bp_first_ack", 64'(bus.eng_done_ack_o), 64'(4'b0001));
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 64'(bus.cmpl_valid_o), 64'(1));
            check("bp_eng", 64'(bus.cmpl_eng_o), 64'(0));
            check("bp_ack", 64'(bus.eng_done_ack_o), 64'(0));
            check("bp_busy", 64'(busy_o), 64'(4'b1110));
        end
        check("bp_pasid", 64'(bus.cmpl_pasid_o), 64'(PW'(200)));
        cmpl_rdy = 1'b1;
        repeat (6) step();
        check("bp_n", 64'(cmpl_cyc.size()), 64'(3));
        check("bp_stream", 64'((cmpl_cyc.size() == 3) ? cmpl_cyc[2] - cmpl_cyc[0] : 0), 64'(2));
        check("bp_ccnt", 64'(completed_cnt_o), 64'(3));
        check("bp_sb", 64'(sb.size()), 64'(0));

        // Halt: no pops while halted, but an ISSUE already started finishes.
        do_reset();
        en = 4'hF;
        halt = 1'b1;
        for (int j = 0; j < 3; j++) push_dsc(PW'(300 + j));
        repeat (10) step();
        check("halt_nopull", 64'(n_pull), 64'(0));
        halt = 1'b0;
        eng_rdy = '0;
        step();
        halt = 1'b1;
        en = '0;
        repeat (3) step();
        check("halt_issue_held", 64'(bus.eng_valid_o), 64'(4'b0001));
        eng_rdy = '1;
        en = 4'hF;
        repeat (5) step();
        check("halt_ndisp", 64'(disp_log.size()), 64'(1));
        check("halt_npull", 64'(n_pull), 64'(1));
        check("halt_busy", 64'(busy_o), 64'(4'b0001));
        done_lvl[2] = 1'b1;
        bad = 0;
        repeat (4) begin
            step();
            if (bus.eng_done_ack_o != '0 || bus.cmpl_valid_o) bad = 1;
        end
        check("ignored_done", 64'(bad), 64'(0));
        done_lvl[2] = 1'b0;
        raise_done(4'b0001);
        for (int w = 0; w < 20 && !idle_o; w++) step();
        check("halt_idle", 64'(idle_o), 64'(1));
        check("halt_ccnt", 64'(completed_cnt_o), 64'(1));
        check("halt_left", 64'(fifo.size()), 64'(2));

        // Asynchronous reset while engine 1 holds an offer.
        do_reset();
        en = 4'hF;
        push_dsc(9'h0AA); push_dsc(9'h0BB);
        repeat (2) step();
        eng_rdy = '0;
        repeat (2) step();
        check("rst_pre_valid", 64'(bus.eng_valid_o), 64'(4'b0010));
        resetn = 1'b0;
        #1;
        check("arst_valid", 64'(bus.eng_valid_o), 64'(0));
        check("arst_pull_ack", 64'({bus.dsc_pull_o, bus.eng_done_ack_o}), 64'(0));
        check("arst_busy", 64'(busy_o), 64'(0));
        check("arst_idle", 64'(idle_o), 64'(1));
        check("arst_cnt", 64'(dispatched_cnt_o), 64'(0));
        check("arst_data", 64'(bus.eng_data_o == '0), 64'(1));
        check("arst_cmpl", 64'({bus.cmpl_valid_o, bus.cmpl_eng_o, bus.cmpl_pasid_o}), 64'(0));
        do_reset();
        en = 4'hF;
        push_dsc(9'h0CC);
        repeat (4) step();
        check("arst_next_eng", 64'((disp_log.size() > 0) ? disp_log[0] : 99), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dsc_dispatcher.md
# dsc_dispatcher

Round-robin scheduler between the job manager's descriptor FIFO (dsc0 ready/pull/data) and NUM_ENGINES action engines. It pops one descriptor at a time, hands it to the next enabled idle engine, and tracks per-engine busy state until the engine reports completion. It also serialises completions, tagged with engine index and PASID, onto a single completion channel for the completion/interrupt logic.

## Interface
- NUM_ENGINES, 4, number of engines served (1..16)
- DATA_WIDTH, 1024, descriptor width
- PASID_WIDTH, 9, PASID field width
- ENG_ID_WIDTH, 4, engine index width (≥ clog2(NUM_ENGINES))
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- dsc_ready_i  in  1  descriptor FIFO non-empty; dsc_data_i valid (first-word-fall-through)
- dsc_data_i  in  DATA_WIDTH  head descriptor; PASID in [1000:992]
- dsc_pull_o  out  1  one-cycle pop of the descriptor FIFO
- eng_enable_i  in  NUM_ENGINES  per-engine dispatch enable (config)
- halt_i  in  1  stop issuing new descriptors; in-flight work continues
- eng_valid_o  out  NUM_ENGINES  one-hot descriptor-valid to engines
- eng_ready_i  in  NUM_ENGINES  engine accepts descriptor
- eng_data_o  out  DATA_WIDTH  descriptor shared by all engines
- eng_done_i  in  NUM_ENGINES  level; held by engine until acked
- eng_done_ack_o  out  NUM_ENGINES  one-hot, one-cycle completion acknowledge
- cmpl_valid_o  out  1  completion record valid
- cmpl_ready_i  in  1  completion consumer ready
- cmpl_eng_o  out  ENG_ID_WIDTH  engine that completed
- cmpl_pasid_o  out  PASID_WIDTH  PASID of the completed descriptor
- busy_o  out  NUM_ENGINES  engine holds an outstanding descriptor
- idle_o  out  1  FSM in IDLE, no busy engine, no pending completion
- dispatched_cnt_o  out  32  descriptors issued, wraps
- completed_cnt_o  out  32  completions delivered, wraps

## Operation
- Dispatch FSM: IDLE, ISSUE.
- IDLE → ISSUE when dsc_ready_i & !halt_i & (eng_enable_i & ~busy) != 0.
  - In the same cycle: dsc_pull_o=1, dsc_data_i latched into the holding register, and the grant latched.
  - Grant is round-robin over eligible engines, starting after the last granted index. The pointer resets to NUM_ENGINES-1, so engine 0 is served first.
- ISSUE: eng_valid_o[grant]=1 and eng_data_o=holding register, both stable until eng_ready_i[grant].
  - On handshake: busy[grant] set, PASID stored in pasid_tab[grant], dispatched_cnt += 1, return to IDLE.
  - halt_i and eng_enable_i changes do not cancel an ISSUE in progress.
- Completion path (independent of the FSM):
  - Candidates: eng_done_i & busy.
  - When the output register is empty or being drained (cmpl_valid_o & cmpl_ready_i), load the lowest-index candidate: cmpl_eng_o=index, cmpl_pasid_o=pasid_tab[index], eng_done_ack_o[index]=1 for one cycle, busy[index] cleared.
  - completed_cnt += 1 on the cmpl handshake.
  - eng_done_i on a non-busy engine is ignored; no ack is issued.
- A completion for engine k and a new grant of engine k may not occur in the same cycle. The grant uses the registered busy, so k becomes eligible the cycle after its busy clears.
- Reset values:
  - All outputs 0: eng_valid_o, dsc_pull_o, eng_done_ack_o, cmpl_valid_o, busy_o, counters, eng_data_o, cmpl_eng_o, cmpl_pasid_o.
  - idle_o=1.
  - FSM IDLE; holding register and pasid_tab cleared.
- Reset mid-operation is asynchronous. The descriptor held in ISSUE is dropped; the job manager FIFO has already popped it, which is acceptable (software resubmits).

## Timing
- dsc_ready_i rise → dsc_pull_o same cycle (combinational from registered state). eng_valid_o asserts the next cycle.
- Minimum dispatch period 2 cycles: an IDLE cycle plus an ISSUE cycle with immediate ready.
- eng_done_i → cmpl_valid_o and eng_done_ack_o the next cycle. The engine must drop eng_done_i the cycle after the ack.
- Sustained completion throughput: 1 per cycle while cmpl_ready_i=1.
- Counters update the cycle after their handshake and wrap 0xFFFFFFFF → 0.

## Structure
- Package dsc_pkg holds:
  - PASID_LSB=992 and PASID_MSB=1000.
  - Descriptor magic 16'h20F8 at [31:16] and valid bit 0.
  - FSM state typedef {IDLE, ISSUE}.
- Sub-module rr_arbiter (NUM_ENGINES request vector → one-hot grant plus index). The pointer updates only on an accepted grant. It is reusable by other schedulers.

## Test plan
- Reset: resetn low mid-ISSUE → all outputs 0, idle_o=1, next grant goes to engine 0.
- Four descriptors, NUM_ENGINES=4, all enabled, ready tied high → grants 0,1,2,3 on cycles 2,4,6,8; dispatched_cnt=4; busy_o=4'hF; 5th descriptor waits, dsc_pull_o stays 0.
- eng_enable_i=4'b0101 with 3 descriptors → engines 0, 2, then 0 again only after engine 0 completes.
- Engines 1 and 3 raise done in the same cycle, cmpl_ready_i=1 → record engine 1 then engine 3 on consecutive cycles with the correct PASIDs (e.g. 9'h05, 9'h1A); completed_cnt=2.
- halt_i=1 with descriptors pending → no dsc_pull_o; an in-flight ISSUE completes; idle_o=1 once completions drain.
- cmpl_ready_i=0 for 10 cycles with 3 engines done → one record held stable, no further acks, busy retained; on release the three records stream in index order.
